msgmii_rst_seq: RTL and testbench

//  Reset sequencer for the SGMII MAC clock/reset block. Holds the global MAC reset while the SerDes PLL acquires lock.
//  It then releases the per-clock-domain reset requests one at a time, in a fixed order.
//  It re-sequences when lock is lost or software requests a reset. Sits between the PLL/CSR logic and the clock/reset synchroniser.
//  Its outputs feed the synchroniser's reset-request inputs.

---
 rtl/msgmii_rst_seq.sv | 178 +++++++++++++++++
 tb/tb_msgmii_rst_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msgmii_rst_seq.sv
// ----------------------------------------------------------------------------
// msgmii_rst_seq
//
// Reset sequencer for the SGMII MAC clock/reset block. It holds the global
// MAC reset while the SerDes PLL acquires lock. It then releases the
// per-clock-domain reset requests one at a time, lowest bit first. It
// re-sequences from scratch when lock is lost or software asks for a reset.
//
// Ports
//   clk       in   1        system clock, all logic on posedge
//   rst_n     in   1        synchronous active-low reset
//   pll_lock  in   1        PLL lock (asynchronous, 2-flop synchronised here)
//   sw_rst    in   1        software reset request, level sensitive
//   rst_all   out  1        global reset request, active-high, registered
//   rst_dom   out  NUM_DOM  per-domain reset requests, bit 0 released first
//   ready     out  1        high only while in RUN
//   lock_err  out  1        sticky lock-timeout flag
//   state_o   out  3        current FSM state (debug/CSR)
//
// Handshake: there is no valid/ready traffic here. pll_lock and sw_rst are
// plain levels. The outputs are levels, and the synchroniser downstream
// samples them every cycle.
// ----------------------------------------------------------------------------
module msgmii_rst_seq #(
    parameter int NUM_DOM     = 5,
    parameter int HOLD_CYC    = 64,
    parameter int STAGGER_CYC = 8,
    parameter int LOCK_TO_CYC = 65535,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               sw_rst,
    output logic               rst_all,
    output logic [NUM_DOM-1:0] rst_dom,
    output logic               ready,
    output logic               lock_err,
    output logic [2:0]         state_o
);

    localparam logic [2:0] ST_ASSERT    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_SETTLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_TO_LAST = CNT_W'(LOCK_TO_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOM - 1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   dom_idx;
    logic [1:0]         sync_q;
    logic               lock_s;

    logic [2:0]         nxt_state;
    logic [CNT_W-1:0]   nxt_cnt;
    logic [IDX_W-1:0]   nxt_idx;
    logic               set_err;
    logic [NUM_DOM-1:0] nxt_dom;

    assign lock_s  = sync_q[1];
    assign state_o = state;

    // Next-state logic. cnt goes back to zero on every state change, so it
    // never wraps.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 1'b1;
        nxt_idx   = dom_idx;
        set_err   = 1'b0;
        if (sw_rst) begin
            // Software reset beats every other transition. While it is held,
            // it keeps restarting the ASSERT count.
            nxt_state = ST_ASSERT;
            nxt_cnt   = '0;
            nxt_idx   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_cnt   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt_state = ST_SETTLE;
                        nxt_cnt   = '0;
                    end else if (cnt == LOCK_TO_LAST) begin
                        nxt_state = ST_ASSERT;
                        nxt_cnt   = '0;
                        set_err   = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        nxt_state = ST_WAIT_LOCK;
                        nxt_cnt   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        nxt_state = ST_RELEASE;
                        nxt_cnt   = '0;
                        nxt_idx   = '0;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        nxt_state = ST_ASSERT;
                        nxt_cnt   = '0;
                    end else if (cnt == STAGGER_LAST) begin
                        nxt_cnt = '0;
                        if (dom_idx == IDX_LAST) begin
                            nxt_state = ST_RUN;
                        end else begin
                            nxt_idx = dom_idx + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    nxt_cnt = '0;
                    if (!lock_s) begin
                        nxt_state = ST_ASSERT;
                    end
                end
                default: begin
                    nxt_state = ST_ASSERT;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end
            endcase
        end
    end

    // Domain mask, decoded from the next state. That way the registered
    // outputs move in the same cycle as the state register.
    always_comb begin
        nxt_dom = '1;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (nxt_state == ST_RUN) begin
                nxt_dom[i] = 1'b0;
            end else if (nxt_state == ST_RELEASE) begin
                nxt_dom[i] = (i > int'(nxt_idx));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            dom_idx  <= '0;
            sync_q   <= '0;
            rst_all  <= 1'b1;
            rst_dom  <= '1;
            ready    <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            dom_idx  <= nxt_idx;
            sync_q   <= {sync_q[0], pll_lock};
            rst_all  <= !((nxt_state == ST_RELEASE) || (nxt_state == ST_RUN));
            rst_dom  <= nxt_dom;
            ready    <= (nxt_state == ST_RUN);
            if (sw_rst) begin
                lock_err <= 1'b0;
            end else if (set_err) begin
                lock_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msgmii_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_msgmii_rst_seq
//
// Bench for msgmii_rst_seq with NUM_DOM=3, HOLD_CYC=4, STAGGER_CYC=2 and
// LOCK_TO_CYC=10. The reference model tracks the current phase and the
// time spent in it. It derives the released-domain count from the elapsed
// time in RELEASE.
// ----------------------------------------------------------------------------
module tb_msgmii_rst_seq;

  localparam int N  = 3;
  localparam int H  = 4;
  localparam int ST = 2;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_lock = 1'b0;
  logic         sw_rst = 1'b0;
  logic         rst_all;
  logic [N-1:0] rst_dom;
  logic         ready;
  logic         lock_err;
  logic [2:0]   state_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int ph = 0;
  int el = 0;
  bit m_err = 1'b0;
  bit lp0 = 1'b0;
  bit lp1 = 1'b0;

  msgmii_rst_seq #(
    .NUM_DOM(N), .HOLD_CYC(H), .STAGGER_CYC(ST), .LOCK_TO_CYC(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sw_rst(sw_rst),
    .rst_all(rst_all), .rst_dom(rst_dom), .ready(ready),
    .lock_err(lock_err), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  // Model phases: 0 assert, 1 wait lock, 2 settle, 3 release, 4 run.
  function automatic logic exp_all();
    return !(ph == 3 || ph == 4);
  endfunction

  function automatic logic [N-1:0] exp_dom();
    logic [N-1:0] d;
    int rel;
    d = '1;
    if (ph == 4) d = '0;
    else if (ph == 3) begin
      rel = el / ST + 1;
      if (rel > N) rel = N;
      for (int i = 0; i < rel; i++) d[i] = 1'b0;
    end
    return d;
  endfunction

  function automatic logic [8:0] exp_vec();
    return {exp_all(), exp_dom(), logic'(ph == 4), logic'(m_err), 3'(ph)};
  endfunction

  // Advance one clock and step the model with the inputs at that edge.
  // Outputs are sampled 1 time unit after the edge.
  task automatic tick();
    bit ls;
    @(posedge clk);
    if (!rst_n) begin
      ph = 0; el = 0; m_err = 1'b0; lp0 = 1'b0; lp1 = 1'b0;
    end else begin
      ls = lp1;
      if (sw_rst) begin
        ph = 0; el = 0; m_err = 1'b0;
      end else begin
        case (ph)
          0: if (el == H - 1) begin ph = 1; el = 0; end else el++;
          1: if (ls) begin ph = 2; el = 0; end
             else if (el == TO - 1) begin m_err = 1'b1; ph = 0; el = 0; end
             else el++;
          2: if (!ls) begin ph = 1; el = 0; end
             else if (el == H - 1) begin ph = 3; el = 0; end
             else el++;
          3: if (!ls) begin ph = 0; el = 0; end
             else if (el == N * ST - 1) begin ph = 4; el = 0; end
             else el++;
          default: if (!ls) begin ph = 0; el = 0; end
        endcase
      end
      lp1 = lp0;
      lp0 = pll_lock;
    end
    #1;
  endtask

  // driver: synchronous reset pulse, leaves bench at cycle c0
  task automatic do_reset();
    rst_n = 1'b0;
    sw_rst = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pll_lock = 1'b0;
    do_reset();
    n_vec++;
    if ({rst_all, rst_dom, ready, lock_err, state_o} !== {1'b1, 3'b111, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset: got all=%b dom=%b rdy=%b err=%b st=%0d, want 1 111 0 0 0",
               rst_all, rst_dom, ready, lock_err, state_o);
    end
  endtask

  task automatic test_nominal();
    pll_lock = 1'b1;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_vec++;
      if ({rst_all, rst_dom, ready, lock_err, state_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL nominal_model c%0d: got %b want %b", c,
                 {rst_all, rst_dom, ready, lock_err, state_o}, exp_vec());
      end
      if (c == 4 || c == 5 || c == 9 || c == 11 || c == 13 || c == 15) begin
        n_vec++;
        if ((c == 4 && state_o !== 3'd1) || (c == 5 && state_o !== 3'd2) ||
            (c == 9 && (rst_all !== 1'b0 || rst_dom !== 3'b110)) ||
            (c == 11 && rst_dom !== 3'b100) || (c == 13 && rst_dom !== 3'b000) ||
            (c == 15 && ready !== 1'b1)) begin
          n_err++;
          $display("FAIL nominal_timeline c%0d: got st=%0d all=%b dom=%b rdy=%b",
                   c, state_o, rst_all, rst_dom, ready);
        end
      end
    end
  endtask

  task automatic test_no_lock();
    bit seen_run;
    pll_lock = 1'b0;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_vec++;
      if ({rst_all, rst_dom, ready, lock_err, state_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL nolock_model c%0d: got %b want %b", c,
                 {rst_all, rst_dom, ready, lock_err, state_o}, exp_vec());
      end
      if ((c >= 4 && c <= 13) || c == 14) begin
        n_vec++;
        if ((c <= 13 && (state_o !== 3'd1 || lock_err !== 1'b0)) ||
            (c == 14 && (state_o !== 3'd0 || lock_err !== 1'b1))) begin
          n_err++;
          $display("FAIL nolock_timeout c%0d: got st=%0d err=%b", c, state_o, lock_err);
        end
      end
    end
    // The flag is sticky: reaching RUN does not clear it.
    pll_lock = 1'b1;
    seen_run = 1'b0;
    for (int c = 0; c < 40 && !seen_run; c++) begin
      tick();
      if (ph == 4) seen_run = 1'b1;
    end
    n_vec++;
    if (!seen_run || ready !== 1'b1 || lock_err !== 1'b1) begin
      n_err++;
      $display("FAIL nolock_sticky: got rdy=%b err=%b want 1 1 (run seen=%b)",
               ready, lock_err, seen_run);
    end
  endtask

  task automatic test_settle_glitch();
    pll_lock = 1'b1;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 6) pll_lock = 1'b0;
      if (c == 7) pll_lock = 1'b1;
      n_vec++;
      if ({rst_all, rst_dom, ready, lock_err, state_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL glitch_model c%0d: got %b want %b", c,
                 {rst_all, rst_dom, ready, lock_err, state_o}, exp_vec());
      end
      if ((c <= 13 && rst_all !== 1'b1) || (c == 9 && state_o !== 3'd1) ||
          (c == 10 && state_o !== 3'd2) || (c == 14 && state_o !== 3'd3)) begin
        n_err++;
        $display("FAIL glitch_timeline c%0d: got st=%0d all=%b", c, state_o, rst_all);
      end
    end
  endtask

  task automatic test_run_lock_loss();
    pll_lock = 1'b1;
    do_reset();
    for (int c = 1; c <= 39; c++) begin
      tick();
      if (c == 16) pll_lock = 1'b0;
      if (c == 19) pll_lock = 1'b1;
      n_vec++;
      if ({rst_all, rst_dom, ready, lock_err, state_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL lockloss_model c%0d: got %b want %b", c,
                 {rst_all, rst_dom, ready, lock_err, state_o}, exp_vec());
      end
      if ((c == 18 && ready !== 1'b1) ||
          (c == 19 && {state_o, rst_all, rst_dom, ready} !== {3'd0, 1'b1, 3'b111, 1'b0}) ||
          (c == 34 && ready !== 1'b1)) begin
        n_err++;
        $display("FAIL lockloss_timeline c%0d: got st=%0d all=%b dom=%b rdy=%b",
                 c, state_o, rst_all, rst_dom, ready);
      end
    end
  endtask

  task automatic test_sw_rst_release();
    int guard;
    pll_lock = 1'b0;
    do_reset();
    for (int c = 1; c <= 14; c++) tick();
    n_vec++;
    if (lock_err !== 1'b1) begin
      n_err++;
      $display("FAIL swrst_precond: got err=%b want 1", lock_err);
    end
    pll_lock = 1'b1;
    guard = 0;
    while (!(ph == 3 && exp_dom() == 3'b100) && guard < 60) begin
      tick();
      guard++;
    end
    n_vec++;
    if (guard >= 60 || rst_dom !== 3'b100 || state_o !== 3'd3) begin
      n_err++;
      $display("FAIL swrst_reach_release: got st=%0d dom=%b after %0d cycles, want 3 100",
               state_o, rst_dom, guard);
    end
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    n_vec++;
    if ({state_o, rst_all, rst_dom, lock_err} !== {3'd0, 1'b1, 3'b111, 1'b0}) begin
      n_err++;
      $display("FAIL swrst_pulse: got st=%0d all=%b dom=%b err=%b, want 0 1 111 0",
               state_o, rst_all, rst_dom, lock_err);
    end
  endtask

  task automatic test_rst_n_run();
    pll_lock = 1'b1;
    do_reset();
    for (int c = 1; c <= 16; c++) tick();
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstn_run_precond: got rdy=%b want 1", ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({ready, rst_all, rst_dom, state_o} !== {1'b0, 1'b1, 3'b111, 3'd0}) begin
      n_err++;
      $display("FAIL rstn_run: got rdy=%b all=%b dom=%b st=%0d, want 0 1 111 0",
               ready, rst_all, rst_dom, state_o);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    pll_lock = 1'b1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      sw_rst = ($urandom_range(0, 199) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
      n_vec++;
      if ({rst_all, rst_dom, ready, lock_err, state_o} !== exp_vec()) begin
        n_err++;
        $display("FAIL random_model k%0d: got %b want %b", k,
                 {rst_all, rst_dom, ready, lock_err, state_o}, exp_vec());
      end
    end
    sw_rst = 1'b0;
    rst_n  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_lock();
    test_settle_glitch();
    test_run_lock_loss();
    test_sw_rst_release();
    test_rst_n_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
